adder_tree_sched: RTL and testbench
===================================

Name: adder_tree_sched

Overview:
- Sequencer for the pipelined adder tree in the convolution datapath.
- Streams a dot-product job of N chunks into the tree, one INPUT_NUM-wide chunk per handshake.
- Tracks in-flight chunks with a valid shift register matched to tree latency, accumulates the per-chunk tree sums, and presents one final result on a valid/ready output port.
- Sits between the operand fetch/multiplier stage (upstream) and the output writeback (downstream).

Parameters:
- WIDTH, 32: bit width of each operand, tree sum and accumulator.
- INPUT_NUM, 8: operands per chunk; equals the tree fan-in.
- TREE_LAT, $clog2(INPUT_NUM): tree latency in cycles, input to result. Must be >= 1.
- CNT_W, 16: width of the chunk-count configuration.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_chunks  in  CNT_W  chunk count for the job; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  upstream chunk valid.
- in_ready  out  1  high only in FEED.
- in_data  in  INPUT_NUM*WIDTH  chunk operands, packed [INPUT_NUM-1:0][WIDTH-1:0].
- tree_in  out  INPUT_NUM*WIDTH  combinational copy of in_data.
- tree_in_valid  out  1  equals in_valid && in_ready.
- tree_res  in  WIDTH  tree sum for the chunk presented TREE_LAT cycles earlier.
- out_valid  out  1  final result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  accumulated result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; remaining count=0; acc=0; vld_pipe=0.
  - in_ready=0, out_valid=0, busy=0, out_data=0.
  - Reset mid-job discards the job, including in-flight tree results.
- FSM states: IDLE, FEED, DRAIN, OUT.
- IDLE:
  - start=1 with cfg_chunks!=0: latch remaining=cfg_chunks, clear acc, go to FEED.
  - start=1 with cfg_chunks==0: clear acc, go directly to OUT (result 0).
- FEED:
  - in_ready=1.
  - Each handshake (in_valid && in_ready): decrement remaining and shift a 1 into vld_pipe[0].
  - Handshake with remaining==1: go to DRAIN.
  - in_valid low: stall; remaining holds, pipe still advances and shifts in 0.
- vld_pipe:
  - TREE_LAT bits, shifts every cycle in all states.
  - When vld_pipe[TREE_LAT-1]=1, acc <= acc + tree_res at that edge.
  - Addition wraps modulo 2^WIDTH; no saturation, no overflow flag.
- DRAIN:
  - in_ready=0.
  - When vld_pipe is all zero, go to OUT on the next edge.
- OUT:
  - out_valid=1, out_data=acc; both hold stable until out_ready.
  - out_valid && out_ready: go to IDLE.
  - acc keeps its value until the next accepted start.
- Latency:
  - out_valid rises TREE_LAT+1 edges after the edge accepting the last chunk.
  - Zero-length job: out_valid rises 1 edge after start.
- start outside IDLE is ignored; cfg_chunks changes outside IDLE are ignored.
- Back-to-back jobs: start sampled in the IDLE cycle directly after the OUT handshake is accepted. No start is accepted during OUT.
- out_data outside OUT shows acc (don't-care for consumers). out_valid=0 outside OUT.

Test Plan:
- Basic job (INPUT_NUM=8, TREE_LAT=3): cfg_chunks=3, every operand=1, bench tree model returns lane sum after 3 cycles, in_valid held high.
  -> exactly 3 handshakes; out_data=24; out_valid 4 edges after the 3rd handshake; busy high from start until the OUT handshake.
- Upstream stalls: cfg_chunks=4, chunk sums 10/20/30/40, in_valid toggling 1,0,0,1,1,0,1.
  -> remaining decrements only on handshakes; out_data=100; no result lost or counted twice.
- Output backpressure: finish a job with result 0x55, hold out_ready=0 for 5 cycles.
  -> out_valid and out_data stay stable; start pulses during OUT ignored; return to IDLE one edge after out_ready=1.
- Wrap and zero length: chunk sums 0xFFFFFFFF and 0x2 -> out_data=0x1. Separately, cfg_chunks=0 -> out_valid=1 with out_data=0 one edge after start, in_ready never asserted.
- Reset mid-job: assert rst=0 in DRAIN with vld_pipe nonzero.
  -> all outputs 0 immediately. Next job of cfg_chunks=1 with sum 7 -> out_data=7, no stale contribution.

Source files
------------

// File: rtl/adder_tree_sched.sv
// Sequencer for the pipelined adder tree: feeds chunks of a dot-product job into the tree,
// tracks them through its latency with a valid shift register and accumulates the per-chunk sums.
module adder_tree_sched #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8,
    parameter int TREE_LAT  = $clog2(INPUT_NUM),
    parameter int CNT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [CNT_W-1:0]                     cfg_chunks,
    output logic                                 busy,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [INPUT_NUM-1:0][WIDTH-1:0]      in_data,
    output logic [INPUT_NUM-1:0][WIDTH-1:0]      tree_in,
    output logic                                 tree_in_valid,
    input  logic [WIDTH-1:0]                     tree_res,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [TREE_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic                  hs;
    logic                  start_ok;

    if (TREE_LAT < 1) begin : g_bad_lat
        $error("adder_tree_sched: TREE_LAT must be at least 1");
    end

    // Accumulation wraps modulo 2^WIDTH by construction.
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    assign in_ready      = (state_q == FEED);
    assign hs            = in_valid && in_ready;
    assign tree_in       = in_data;
    assign tree_in_valid = hs;
    assign busy          = (state_q != IDLE);
    assign out_valid     = (state_q == OUT);
    assign out_data      = acc_q;

    // Valid bit travels alongside each chunk for exactly the tree latency.
    if (TREE_LAT == 1) begin : g_pipe_one
        assign vld_pipe_d = hs;
    end else begin : g_pipe_many
        assign vld_pipe_d = {vld_pipe_q[TREE_LAT-2:0], hs};
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        start_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (cfg_chunks != '0) begin
                        rem_d   = cfg_chunks;
                        state_d = FEED;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            FEED: begin
                if (hs) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld_pipe_q == '0) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new job clears the accumulator; the pipe is always empty in IDLE so the two never collide.
    always_comb begin
        acc_d = acc_q;
        if (start_ok) begin
            acc_d = '0;
        end else if (vld_pipe_q[TREE_LAT-1]) begin
            acc_d = wrap_add(acc_q, tree_res);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            acc_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

endmodule

// File: tb/tb_adder_tree_sched.sv
// Self-checking bench for adder_tree_sched: a behavioural tree model feeds tree_res and a
// job-level reference model predicts busy/in_ready/out_valid/out_data every cycle.
module tb_adder_tree_sched;

    localparam int WIDTH     = 32;
    localparam int INPUT_NUM = 8;
    localparam int TREE_LAT  = 3;
    localparam int CNT_W     = 16;

    typedef logic [INPUT_NUM-1:0][WIDTH-1:0] chunk_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_chunks = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    chunk_t           in_data = '0;
    chunk_t           tree_in;
    logic             tree_in_valid;
    logic [WIDTH-1:0] tree_res;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    adder_tree_sched #(
        .WIDTH(WIDTH), .INPUT_NUM(INPUT_NUM), .TREE_LAT(TREE_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_chunks(cfg_chunks), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tree_in(tree_in), .tree_in_valid(tree_in_valid), .tree_res(tree_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] lane_sum(input chunk_t c);
        logic [WIDTH-1:0] s = '0;
        for (int i = 0; i < INPUT_NUM; i++) s = s + c[i];
        return s;
    endfunction

    function automatic chunk_t make_chunk(input logic [WIDTH-1:0] sum);
        chunk_t c;
        logic [WIDTH-1:0] rest = '0;
        for (int i = 1; i < INPUT_NUM; i++) begin
            c[i] = $urandom;
            rest = rest + c[i];
        end
        c[0] = sum - rest;
        return c;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Adder tree stand-in: lane sum of whatever is presented, delivered TREE_LAT edges later.
    logic [WIDTH-1:0] tpipe [TREE_LAT];
    always @(posedge clk) begin
        tpipe[0] <= lane_sum(tree_in);
        for (int i = 1; i < TREE_LAT; i++) tpipe[i] <= tpipe[i-1];
    end
    assign tree_res = tpipe[TREE_LAT-1];

    // Job-level reference: a job is busy from an accepted start until its result is taken.
    bit               m_busy = 0;
    bit               m_feeding = 0;
    bit               m_out = 0;
    int               m_left = 0;
    int               m_countdown = 0;
    logic [WIDTH-1:0] m_sum = '0;
    logic [WIDTH-1:0] m_result = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_feeding = 0; m_out = 0; m_left = 0; m_countdown = 0; m_sum = '0;
        end else if (m_out) begin
            if (out_ready) begin
                m_out = 0;
                m_busy = 0;
            end
        end else if (!m_busy) begin
            if (start) begin
                m_sum = '0;
                m_busy = 1;
                if (cfg_chunks == '0) begin
                    m_out = 1;
                    m_result = '0;
                end else begin
                    m_feeding = 1;
                    m_left = int'(cfg_chunks);
                end
            end
        end else if (m_feeding) begin
            if (in_valid) begin
                m_sum = m_sum + lane_sum(in_data);
                m_left--;
                if (m_left == 0) begin
                    m_feeding = 0;
                    m_countdown = TREE_LAT + 1;
                end
            end
        end else if (m_countdown > 0) begin
            m_countdown--;
            if (m_countdown == 0) begin
                m_out = 1;
                m_result = m_sum;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(0));
            check("rst_out_valid", 32'(out_valid), 32'(0));
        end else begin
            check("busy", 32'(busy), 32'(m_busy));
            check("in_ready", 32'(in_ready), 32'(m_feeding));
            check("out_valid", 32'(out_valid), 32'(m_out));
            check("tree_in_valid", 32'(tree_in_valid), 32'(in_valid && m_feeding));
            if (tree_in !== in_data) check("tree_in_copy", lane_sum(tree_in), lane_sum(in_data));
            if (m_out) check("out_data", out_data, m_result);
        end
    end

    chunk_t jq[$];
    bit     vpat[$];

    task automatic start_job(input int cfg);
        @(posedge clk); #2;
        start = 1'b1;
        cfg_chunks = CNT_W'(cfg);
        @(posedge clk); #2;
        start = 1'b0;
        cfg_chunks = CNT_W'($urandom);
    endtask

    task automatic feed(output int last_hs);
        int idx = 0;
        int p = 0;
        int guard = 0;
        bit v;
        bit hs;
        last_hs = 0;
        while (idx < jq.size() && guard < 300) begin
            v = (vpat.size() == 0) ? 1'b1 : vpat[p % vpat.size()];
            p++;
            in_valid = v;
            in_data = v ? jq[idx] : make_chunk($urandom);
            #1;
            hs = v && in_ready;
            @(posedge clk); #2;
            if (hs) begin
                idx++;
                last_hs = cyc;
            end
            guard++;
        end
        in_valid = 1'b0;
        check("feed_handshakes", 32'(idx), 32'(jq.size()));
    endtask

    task automatic wait_result(output logic [WIDTH-1:0] data, output int rise);
        int g = 0;
        while (!out_valid && g < 100) begin
            @(posedge clk); #2;
            g++;
        end
        check("result_seen", 32'(out_valid), 32'(1));
        data = out_data;
        rise = cyc;
    endtask

    task automatic run_job(input string name, input int cfg, input logic [WIDTH-1:0] exp);
        int last_hs;
        int rise;
        logic [WIDTH-1:0] d;
        start_job(cfg);
        if (cfg > 0) feed(last_hs);
        wait_result(d, rise);
        check(name, d, exp);
        @(posedge clk); #2;
    endtask

    initial begin
        int last_hs;
        int rise;
        int cfg;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("reset_out_data", out_data, 32'(0));
        rst = 1'b1;

        // Basic: three all-ones chunks, in_valid held high.
        jq.delete(); vpat.delete();
        for (int i = 0; i < 3; i++) jq.push_back({INPUT_NUM{32'd1}});
        start_job(3);
        feed(last_hs);
        wait_result(d, rise);
        check("basic_sum", d, 32'd24);
        check("basic_latency", 32'(rise - last_hs), 32'(TREE_LAT + 1));
        @(posedge clk); #2;

        // Upstream stalls.
        jq.delete(); vpat.delete();
        jq.push_back(make_chunk(32'd10)); jq.push_back(make_chunk(32'd20));
        jq.push_back(make_chunk(32'd30)); jq.push_back(make_chunk(32'd40));
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        run_job("stall_sum", 4, 32'd100);

        // Output backpressure with ignored start pulses.
        jq.delete(); vpat.delete();
        jq.push_back(make_chunk(32'h50)); jq.push_back(make_chunk(32'h05));
        out_ready = 1'b0;
        start_job(2);
        feed(last_hs);
        wait_result(d, rise);
        check("bp_sum", d, 32'h55);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            cfg_chunks = CNT_W'(3);
            @(posedge clk); #2;
            check("bp_hold_valid", 32'(out_valid), 32'(1));
            check("bp_hold_data", out_data, 32'h55);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_idle_busy", 32'(busy), 32'(0));
        check("bp_idle_valid", 32'(out_valid), 32'(0));

        // Wrap-around accumulation.
        jq.delete(); vpat.delete();
        jq.push_back(make_chunk(32'hFFFF_FFFF)); jq.push_back(make_chunk(32'h2));
        run_job("wrap_sum", 2, 32'h1);

        // Zero-length job.
        start_job(0);
        check("zero_valid", 32'(out_valid), 32'(1));
        check("zero_data", out_data, 32'(0));
        check("zero_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #2;

        // Reset in DRAIN with chunks still in the tree.
        jq.delete(); vpat.delete();
        for (int i = 0; i < 5; i++) jq.push_back(make_chunk(32'h100 + 32'(i)));
        start_job(5);
        feed(last_hs);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_data", out_data, 32'(0));
        @(posedge clk); #2;
        rst = 1'b1;
        jq.delete(); vpat.delete();
        jq.push_back(make_chunk(32'd7));
        run_job("post_rst_sum", 1, 32'd7);

        // Randomized jobs.
        for (int j = 0; j < 10; j++) begin
            jq.delete(); vpat.delete();
            cfg = $urandom_range(0, 6);
            exp = '0;
            for (int i = 0; i < cfg; i++) begin
                d = $urandom;
                exp = exp + d;
                jq.push_back(make_chunk(d));
            end
            vpat.push_back(1'b1);
            for (int i = $urandom_range(0, 4); i > 0; i--) vpat.push_back(1'($urandom_range(0, 1)));
            run_job("rand_sum", cfg, exp);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
